// File: rtl/drp_pkg.sv
// drp_pkg: shared DRP widths, FSM state type and the register reset table.
package drp_pkg;

    localparam int DRP_ADDR_W = 7;
    localparam int DRP_DATA_W = 16;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} drp_state_e;

    // Register 0x28 powers up all-ones, mirroring the PLL power register.
    function automatic logic [DRP_DATA_W-1:0] drp_reset_value(input logic [DRP_ADDR_W-1:0] addr);
        return (addr == 7'h28) ? 16'hFFFF : 16'h0000;
    endfunction

endpackage

// File: rtl/drp_reg_bank.sv
// drp_reg_bank: DRP register storage with one write port, a combinational
// capture read port and a registered fabric peek port.
module drp_reg_bank
    import drp_pkg::*;
#(
    parameter int DEPTH = 80
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [DRP_ADDR_W-1:0] waddr_i,
    input  logic [DRP_DATA_W-1:0] wdata_i,
    input  logic [DRP_ADDR_W-1:0] raddr_i,
    output logic [DRP_DATA_W-1:0] rdata_o,
    input  logic [DRP_ADDR_W-1:0] peek_addr_i,
    output logic [DRP_DATA_W-1:0] peek_data_o
);

    localparam logic [DRP_ADDR_W:0] LIMIT = (DRP_ADDR_W+1)'(DEPTH);

    logic [DRP_DATA_W-1:0] mem_q [DEPTH];
    logic [DRP_DATA_W-1:0] peek_q;

    // Peek samples before the write lands, so a colliding peek sees the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= drp_reset_value(DRP_ADDR_W'(i));
            peek_q <= '0;
        end else begin
            if (we_i) mem_q[waddr_i] <= wdata_i;
            peek_q <= ({1'b0, peek_addr_i} < LIMIT) ? mem_q[peek_addr_i] : '0;
        end
    end

    assign rdata_o     = ({1'b0, raddr_i} < LIMIT) ? mem_q[raddr_i] : '0;
    assign peek_data_o = peek_q;

endmodule

// File: rtl/drp_responder.sv
// drp_responder: 7-series style DRP target with fixed-latency DRDY over a register bank.
// Define DRP_RESPONDER_PROTOCOL_CHECK_EN to enable the sticky err protocol checker.
module drp_responder
    import drp_pkg::*;
#(
    parameter int                    DEPTH       = 80,
    parameter int                    LATENCY     = 3,
    parameter logic [DRP_ADDR_W-1:0] STATUS_ADDR = 7'h7F
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  den,
    input  logic                  dwe,
    input  logic [DRP_ADDR_W-1:0] daddr,
    input  logic [DRP_DATA_W-1:0] di,
    output logic [DRP_DATA_W-1:0] do_o,
    output logic                  drdy,
    input  logic [DRP_DATA_W-1:0] status_in,
    output logic                  wr_strobe,
    output logic [DRP_ADDR_W-1:0] wr_addr,
    output logic [DRP_DATA_W-1:0] wr_data,
    input  logic [DRP_ADDR_W-1:0] peek_addr,
    output logic [DRP_DATA_W-1:0] peek_data,
    output logic                  err
);

    localparam logic [DRP_ADDR_W:0] LIMIT    = (DRP_ADDR_W+1)'(DEPTH);
    localparam logic [3:0]          CNT_LOAD = 4'(LATENCY - 1);

    drp_state_e            state_q;
    logic [3:0]            cnt_q;
    logic [DRP_ADDR_W-1:0] addr_q, wr_addr_q, sel_addr;
    logic [DRP_DATA_W-1:0] wdata_q, rdata_q, do_q, wr_data_q;
    logic [DRP_DATA_W-1:0] bank_rdata, rd_val, sel_wdata, sel_rdata;
    logic                  we_q, drdy_q, wr_strobe_q;
    logic                  sel_we, go_resp, commit;

    drp_reg_bank #(.DEPTH(DEPTH)) u_bank (
        .clk         (clk),
        .rst_n       (rst_n),
        .we_i        (wr_strobe_q),
        .waddr_i     (wr_addr_q),
        .wdata_i     (wr_data_q),
        .raddr_i     (daddr),
        .rdata_o     (bank_rdata),
        .peek_addr_i (peek_addr),
        .peek_data_o (peek_data)
    );

    assign rd_val = ({1'b0, daddr} < LIMIT) ? bank_rdata :
                    (daddr == STATUS_ADDR)  ? status_in  : '0;

    // With LATENCY=1 the response is built straight from the accepting cycle's inputs.
    assign sel_addr  = (state_q == IDLE) ? daddr  : addr_q;
    assign sel_we    = (state_q == IDLE) ? dwe    : we_q;
    assign sel_wdata = (state_q == IDLE) ? di     : wdata_q;
    assign sel_rdata = (state_q == IDLE) ? rd_val : rdata_q;
    assign go_resp   = ((state_q == IDLE) && den && (LATENCY == 1)) ||
                       ((state_q == WAIT) && (cnt_q <= 4'd1));
    assign commit    = go_resp && sel_we && ({1'b0, sel_addr} < LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            drdy_q      <= 1'b0;
            do_q        <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            drdy_q      <= go_resp;
            do_q        <= (go_resp && !sel_we) ? sel_rdata : '0;
            wr_strobe_q <= commit;
            if (commit) begin
                wr_addr_q <= sel_addr;
                wr_data_q <= sel_wdata;
            end
            case (state_q)
                IDLE: if (den) begin
                    addr_q  <= daddr;
                    we_q    <= dwe;
                    wdata_q <= di;
                    rdata_q <= rd_val;
                    cnt_q   <= CNT_LOAD;
                    state_q <= go_resp ? RESP : WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (go_resp) state_q <= RESP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DRP_RESPONDER_PROTOCOL_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else if ((den && state_q != IDLE) || (dwe && !den)) err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign drdy      = drdy_q;
    assign do_o      = do_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: doc/drp_responder.md
# drp_responder

DRP target (responder) for the host-firmware configuration fabric: answers DEN/DWE/DADDR/DI transactions with DO/DRDY exactly as a 7-series primitive's DRP port does, backed by a 16-bit register bank. It sits on the config clock domain opposite any DRP initiator (PLL/MMCM reprogramming sequencers). It serves as the configuration-register endpoint in hardware and as the bus-accurate stand-in for a PLL DRP port in benches.

## Interface
Parameters:
- DEPTH, 80, number of writable registers at addresses 0..DEPTH-1 (DEPTH ≤ 127)
- LATENCY, 3, cycles from accepted DEN to DRDY (legal range 1..15)
- STATUS_ADDR, 7'h7F, read-only address returning status_in

Ports:
- clk  in  1  configuration clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- den  in  1  transaction enable, one-cycle pulse
- dwe  in  1  write enable, qualified by den
- daddr  in  7  register address, sampled with den
- di  in  16  write data, sampled with den
- do  out  16  read data, valid only while drdy=1, else 16'h0000
- drdy  out  1  one-cycle completion pulse
- status_in  in  16  live status word, sampled at den
- wr_strobe  out  1  one-cycle pulse when a write commits
- wr_addr  out  7  address of committed write
- wr_data  out  16  data of committed write
- peek_addr  in  7  fabric-side read address
- peek_data  out  16  registered register value, 1-cycle latency
- err  out  1  sticky protocol-violation flag

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: den=1 captures daddr, dwe, and di. On a read, it also captures the read value. The counter loads LATENCY-1. Next state is WAIT, or RESP if LATENCY=1.
- WAIT: counter decrements each cycle and moves to RESP at 0.
- RESP: drdy=1 and do=captured read value (0 for writes). Write commit happens this same cycle: register updated, wr_strobe=1, wr_addr/wr_data driven. Next state is IDLE.
- Read value selection:
  - daddr<DEPTH: register content.
  - daddr==STATUS_ADDR: status_in.
  - Otherwise: 16'h0000.
- Writes to daddr≥DEPTH (including STATUS_ADDR) are discarded: no register change, no wr_strobe, but drdy still pulses.
- den while in WAIT or RESP is a violation. It is ignored, and the current transaction proceeds unaffected.
- den is accepted only in IDLE, so the earliest next transaction is the cycle after drdy.
- Peek port:
  - peek_data is the register at peek_addr, registered.
  - Out of range reads as 0.
  - A peek that coincides with a write commit to the same address returns the pre-write value; the new value appears one cycle later.

## Timing
- Reset values:
  - drdy=0, do=0, wr_strobe=0, wr_addr=0, wr_data=0, peek_data=0, err=0.
  - FSM in IDLE.
  - Registers loaded from the package reset table.
- Latency: den in cycle N gives drdy in cycle N+LATENCY, exactly one cycle wide.
- Read data is the register value as of cycle N, not as of the drdy cycle.
- rst_n asserted mid-transaction:
  - Pending transaction is dropped, with no commit and no drdy.
  - Registers return to reset values.
- After rst_n deasserts, den is accepted in the first cycle.

## Configuration
- DRP_RESPONDER_PROTOCOL_CHECK_EN defined:
  - A violating den sets err, which stays set until rst_n.
  - dwe=1 without den also sets err.
- Undefined: violations are silently ignored and err is tied 0.
- In both cases, the transaction behaviour is identical.

## Structure
- Shared package drp_pkg holds:
  - DRP_ADDR_W=7 and DRP_DATA_W=16.
  - The FSM state typedef.
  - The function drp_reset_value(addr) giving per-register reset contents. Defaults to 0, except register 8'h28 = 16'hFFFF, mirroring the PLL power register.
- One sub-module, drp_reg_bank:
  - Storage and reset table.
  - Single write port.
  - Combinational read port for the FSM capture.
  - Registered peek port.
- drp_responder keeps the FSM, latency counter and protocol checker.

## Test plan
- Reset release, read address 8'h28 and address 0 → drdy exactly 3 cycles after den; do=16'hFFFF, then 16'h0000.
- Write 16'hA5C3 to 7'h14, then read 7'h14 → wr_strobe/wr_addr=7'h14/wr_data=16'hA5C3 on the write's drdy cycle; read returns 16'hA5C3; peek_data=16'hA5C3 one cycle after peek_addr=7'h14.
- Write 16'h1234 to STATUS_ADDR with status_in=16'h00BE, then read it → drdy pulses on the write with no wr_strobe; read returns 16'h00BE; reads of 7'h60 return 0.
- With PROTOCOL_CHECK_EN, a second den one cycle after the first → first transaction completes normally, second is ignored, err=1 until rst_n.
- rst_n low for one cycle in WAIT of a write to 7'h08 → no drdy, no wr_strobe; register 7'h08 reads 0 afterwards.
- LATENCY=1 build, back-to-back reads (den every second cycle) → drdy on each cycle following den with correct data.
